// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose
//   Shares one backing-memory port between an instruction-cache read port
//   (I-port) and a data-cache read/write port (D-port). Exactly one memory
//   transaction is outstanding at a time. The D-port normally has priority,
//   but the I-port is guaranteed a grant after STARVE_LIMIT consecutive D
//   grants taken while it was waiting. A transaction that sees no mem_ack
//   for MEM_TIMEOUT cycles is abandoned and reported with an error pulse.
//
// Parameters
//   STARVE_LIMIT : consecutive D grants allowed while ic_req is pending.
//   MEM_TIMEOUT  : mem_req cycles without mem_ack before abort (>= 1).
//
// Ports
//   clk, reset             : clock and synchronous active-high reset
//   ic_req, ic_addr        : I-port read request (held until ic_done)
//   ic_done, ic_err        : I-port completion / timeout-error pulses
//   ic_rdata               : I-port read data, valid in the ic_done cycle
//   dc_req, dc_we          : D-port request and write enable (1 = write)
//   dc_addr, dc_wdata      : D-port address and write data
//   dc_done, dc_err        : D-port completion / timeout-error pulses
//   dc_rdata               : D-port read data, valid in the dc_done cycle
//   mem_req, mem_we        : registered memory request and write enable
//   mem_addr, mem_wdata    : registered memory address and write data
//   mem_ack, mem_rdata     : memory completion strobe and read data
//   busy                   : high whenever the arbiter is not in IDLE
//
// Timing of one transaction (grant in cycle N, ack in cycle M)
//   N     : IDLE, winner's request registered
//   N+1.. : MEM_I / MEM_D, mem_req high
//   M     : mem_ack seen, read data captured
//   M+1   : RESP, done (and err on timeout) pulse, requests ignored
//   M+2   : IDLE again, next arbitration
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic        ic_err,
    output logic [31:0] ic_rdata,

    input  logic        dc_req,
    input  logic        dc_we,
    input  logic [31:0] dc_addr,
    input  logic [31:0] dc_wdata,
    output logic        dc_done,
    output logic        dc_err,
    output logic [31:0] dc_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    // -------------------------------------------------------------------------
    // Widths and constants
    // -------------------------------------------------------------------------
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W   = (MEM_TIMEOUT  < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    // The wait counter holds the number of ack-less mem_req cycles already
    // elapsed; the cycle in which it would step to MEM_TIMEOUT is the last
    // one we wait.
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

    localparam int NUM_PORTS = 2;   // index 0 = I-port, 1 = D-port

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;
    logic [WAIT_W-1:0]   wait_q,      wait_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [31:0]         mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                port_d_q,    port_d_d;   // granted port is the D-port
    logic                err_q,       err_d;      // transaction ended by timeout

    // -------------------------------------------------------------------------
    // Decode of the current cycle
    // -------------------------------------------------------------------------
    logic in_idle;
    logic in_mem;
    logic grant_i;
    logic grant_d;
    logic ack_hit;
    logic timed_out;
    logic cap_en [NUM_PORTS];

    assign in_idle = (state_q == IDLE);
    assign in_mem  = (state_q == MEM_I) || (state_q == MEM_D);

    // D has priority unless the I-port has already been passed over
    // STARVE_LIMIT times in a row.
    assign grant_i = in_idle && ic_req && (!dc_req || (starve_q == STARVE_MAX));
    assign grant_d = in_idle && dc_req && !grant_i;

    // An ack in the last waiting cycle still counts as a normal completion,
    // so the timeout is qualified with !mem_ack.
    assign ack_hit   = in_mem && mem_ack;
    assign timed_out = in_mem && !mem_ack && (wait_q == WAIT_LAST);

    // Read data lands only in the granted port's register, and never for a
    // D-port write.
    assign cap_en[0] = ack_hit && (state_q == MEM_I);
    assign cap_en[1] = ack_hit && (state_q == MEM_D) && !mem_we_q;

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = MEM_I;
                end else if (grant_d) begin
                    state_d = MEM_D;
                end
            end
            MEM_I, MEM_D: begin
                if (ack_hit || timed_out) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Requests are deliberately ignored here; arbitration only
                // happens once we are back in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs decoded from the current state
    // -------------------------------------------------------------------------
    always_comb begin
        busy    = (state_q != IDLE);
        ic_done = 1'b0;
        ic_err  = 1'b0;
        dc_done = 1'b0;
        dc_err  = 1'b0;
        if (state_q == RESP) begin
            if (port_d_q) begin
                dc_done = 1'b1;
                dc_err  = err_q;
            end else begin
                ic_done = 1'b1;
                ic_err  = err_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        starve_d    = starve_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        port_d_d    = port_d_q;
        err_d       = err_q;

        if (grant_i) begin
            starve_d    = '0;
            wait_d      = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = ic_addr;
            mem_wdata_d = '0;
            port_d_d    = 1'b0;
            err_d       = 1'b0;
        end else if (grant_d) begin
            // Only count the grant against the I-port if it was waiting.
            if (!ic_req) begin
                starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + STARVE_W'(1);
            end
            wait_d      = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = dc_we;
            mem_addr_d  = dc_addr;
            mem_wdata_d = dc_wdata;
            port_d_d    = 1'b1;
            err_d       = 1'b0;
        end

        if (in_mem) begin
            if (!mem_ack) begin
                wait_d = wait_q + WAIT_W'(1);
            end
            // Address/data stay registered afterwards; only the strobe drops.
            if (ack_hit || timed_out) begin
                mem_req_d = 1'b0;
            end
            if (ack_hit) begin
                err_d = 1'b0;
            end else if (timed_out) begin
                err_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            port_d_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            port_d_q    <= port_d_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // -------------------------------------------------------------------------
    // Per-port read-data registers. Each holds its value across transactions
    // of the other port, across D writes and across timeouts.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [31:0] rdata_q;
            logic [31:0] rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (cap_en[gi]) begin
                    rdata_d = mem_rdata;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end
        end
    endgenerate

    assign ic_rdata = g_port[0].rdata_q;
    assign dc_rdata = g_port[1].rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. Each episode lists the I-port and D-port
// transactions to issue; a transaction-level model replays the arbitration
// rules over those lists and pushes, in predicted grant order, the expected
// memory request and the expected completion. A memory responder checks each
// new mem_req against the request queue; a monitor checks each done pulse
// against the completion queue. Cycle numbers are the value of cyc at the
// negative edge; a request raised at cyc=c is sampled in cycle c.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int MEM_TIMEOUT  = 255;
    localparam int NEVER        = 1_000_000;
    localparam int TXN_BUDGET   = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done, ic_err;
    logic [31:0] ic_rdata;
    logic        dc_req, dc_we;
    logic [31:0] dc_addr, dc_wdata;
    logic        dc_done, dc_err;
    logic [31:0] dc_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MEM_TIMEOUT  (MEM_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_done   (ic_done),
        .ic_err    (ic_err),
        .ic_rdata  (ic_rdata),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_done   (dc_done),
        .dc_err    (dc_err),
        .dc_rdata  (dc_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        bit          port;      // 0 = I, 1 = D
        bit          err;
        logic [31:0] ic_rd;
        logic [31:0] dc_rd;
        int          done_cyc;  // -1 = not checked
    } rsp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          b2b;       // must rise exactly 2 cycles after previous done
    } mreq_t;

    rsp_t  exp_rsp[$];
    mreq_t exp_mem[$];

    int n_pass  = 0;
    int n_total = 0;
    int n_txn   = 0;
    int last_done_cyc = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired (cyc %0d)", name, cyc);
    endtask

    // Backing-memory contents as seen by reads (writes are not reflected).
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // ---------------------------------------------------------- reference model
    int          m_starve = 0;
    logic [31:0] m_ic_rd  = '0;
    logic [31:0] m_dc_rd  = '0;

    logic [31:0] i_addr[$];
    logic [31:0] d_addr[$];
    logic [31:0] d_wd[$];
    bit          d_we[$];

    // Replays the episode in grant order: D first when both wait, unless the
    // I-port has already been skipped STARVE_LIMIT times.
    task automatic plan_episode(input int lat, input bit to);
        int ii = 0;
        int di = 0;
        bit first = 1'b1;
        bit pick_i;
        mreq_t m;
        rsp_t  r;
        while (ii < i_addr.size() || di < d_addr.size()) begin
            if (ii < i_addr.size() && di < d_addr.size())
                pick_i = (m_starve == STARVE_LIMIT);
            else
                pick_i = (ii < i_addr.size());

            if (pick_i)                  m_starve = 0;
            else if (ii < i_addr.size()) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
            else                         m_starve = 0;

            if (pick_i) begin
                m.we = 1'b0; m.addr = i_addr[ii]; m.wdata = '0;
                if (!to) m_ic_rd = mem_val(i_addr[ii]);
                ii++;
            end else begin
                m.we = d_we[di]; m.addr = d_addr[di]; m.wdata = d_wd[di];
                if (!to && !d_we[di]) m_dc_rd = mem_val(d_addr[di]);
                di++;
            end
            m.b2b = !first;
            exp_mem.push_back(m);
            r.port = !pick_i; r.err = to; r.ic_rd = m_ic_rd; r.dc_rd = m_dc_rd;
            r.done_cyc = (first && lat >= 0) ? cyc + lat : -1;
            exp_rsp.push_back(r);
            first = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------ drivers
    task automatic drive_i(input int n);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            ic_addr = i_addr[k];
            ic_req  = 1'b1;
            do begin
                @(negedge clk);
                w++;
            end while (!ic_done && w < TXN_BUDGET);
            if (!ic_done) fail_now("ic_done_wait");
        end
        ic_req = 1'b0;
    endtask

    task automatic drive_d(input int n);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            dc_addr  = d_addr[k];
            dc_we    = d_we[k];
            dc_wdata = d_wd[k];
            dc_req   = 1'b1;
            do begin
                @(negedge clk);
                w++;
            end while (!dc_done && w < TXN_BUDGET);
            if (!dc_done) fail_now("dc_done_wait");
        end
        dc_req = 1'b0;
    endtask

    task automatic run_episode(input int lat, input bit to);
        @(negedge clk);
        plan_episode(lat, to);
        fork
            drive_i(i_addr.size());
            drive_d(d_addr.size());
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_lists();
        i_addr.delete(); d_addr.delete(); d_wd.delete(); d_we.delete();
    endtask

    task automatic add_d(input logic [31:0] a, input bit we, input logic [31:0] wd);
        d_addr.push_back(a); d_we.push_back(we); d_wd.push_back(wd);
    endtask

    // ---------------------------------------------------------- memory responder
    int          ack_delay   = -1;   // -1 = random 0..4, NEVER = no ack
    bit          spurious_en = 1'b0; // random acks while mem_req is low
    int          cur_delay   = 0;
    int          wcnt        = 0;
    bit          prev_req    = 1'b0;
    bit          prev_busy   = 1'b0;
    bit          stable      = 1'b1;
    mreq_t       cap;

    always @(negedge clk) begin : responder
        mreq_t e;
        if (mem_req === 1'b1) begin
            if (!prev_req) begin
                wcnt      = 0;
                stable    = 1'b1;
                cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
                chk("grant_from_idle", {31'b0, prev_busy}, 32'd0);
                if (exp_mem.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_mem_req: addr 0x%08h, none expected (cyc %0d)", mem_addr, cyc);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_we",   {31'b0, mem_we}, {31'b0, e.we});
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    if (e.b2b) chk("b2b_rise_cycle", cyc, last_done_cyc + 2);
                end
                cap.we = mem_we; cap.addr = mem_addr; cap.wdata = mem_wdata;
            end else begin
                wcnt++;
                if (mem_we !== cap.we || mem_addr !== cap.addr || mem_wdata !== cap.wdata)
                    stable = 1'b0;
            end
            mem_ack   = (wcnt == cur_delay);
            mem_rdata = mem_ack ? mem_val(mem_addr) : $urandom;
        end else begin
            if (prev_req) chk("mem_stable", {31'b0, stable}, 32'd1);
            mem_ack   = spurious_en && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
        prev_req  = (mem_req === 1'b1);
        prev_busy = (busy === 1'b1);
    end

    // ------------------------------------------------------------------ monitor
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (ic_done === 1'b1 || dc_done === 1'b1 || ic_err === 1'b1 || dc_err === 1'b1) begin
            if (exp_rsp.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: ic_done=%0b dc_done=%0b ic_err=%0b dc_err=%0b, none expected (cyc %0d)",
                         ic_done, dc_done, ic_err, dc_err, cyc);
            end else begin
                e = exp_rsp.pop_front();
                n_txn++;
                chk("ic_done",  {31'b0, ic_done}, {31'b0, !e.port});
                chk("dc_done",  {31'b0, dc_done}, {31'b0, e.port});
                chk("ic_err",   {31'b0, ic_err},  {31'b0, !e.port && e.err});
                chk("dc_err",   {31'b0, dc_err},  {31'b0, e.port && e.err});
                chk("ic_rdata", ic_rdata, e.ic_rd);
                chk("dc_rdata", dc_rdata, e.dc_rd);
                chk("mem_req_low_at_done", {31'b0, mem_req}, 32'd0);
                chk("busy_at_done", {31'b0, busy}, 32'd1);
                if (e.done_cyc >= 0) chk("done_latency", cyc, e.done_cyc);
                $display("txn %0d: cyc %0d port=%s err=%0b ic_rdata=0x%08h dc_rdata=0x%08h",
                         n_txn, cyc, e.port ? "D" : "I", e.err, ic_rdata, dc_rdata);
            end
            last_done_cyc = cyc;
        end
    end

    // ------------------------------------------------------------- stimulus
    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int w;
        reset = 1'b1; ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_mem_req",   {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we",    {31'b0, mem_we},  32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_done_err",  {28'b0, ic_done, ic_err, dc_done, dc_err}, 32'd0);
        chk("rst_ic_rdata",  ic_rdata, 32'd0);
        chk("rst_dc_rdata",  dc_rdata, 32'd0);
        chk("rst_busy",      {31'b0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single I read, ack on first mem_req cycle: done in the third cycle
        // counting the sampling cycle.
        ack_delay = 0;
        clear_lists(); i_addr.push_back(32'h0000_0040);
        run_episode(2, 1'b0);

        // D read then D write, each acked after 2 wait cycles.
        ack_delay = 2;
        clear_lists();
        add_d(32'h0000_0200, 1'b0, 32'h0);
        add_d(32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
        run_episode(4, 1'b0);

        // Starvation: both held, expect D,D,D,D,I,D,D,D,D,I.
        ack_delay = 0;
        clear_lists();
        i_addr.push_back(32'h0000_1000); i_addr.push_back(32'h0000_1004);
        for (int k = 0; k < 8; k++) add_d(32'h0000_2000 + 32'(k * 4), 1'(k % 2), 32'h1111_0000 + 32'(k));
        run_episode(-1, 1'b0);

        // Timeout: no ack at all; 255 mem_req cycles, done+err in RESP.
        ack_delay = NEVER;
        clear_lists(); i_addr.push_back(32'h0000_3000);
        run_episode(MEM_TIMEOUT + 1, 1'b1);

        // Reset in MEM_D with mem_ack in the same cycle.
        ack_delay = 0;
        @(negedge clk);
        begin
            mreq_t m;
            m.we = 1'b0; m.addr = 32'h0000_4000; m.wdata = '0; m.b2b = 1'b0;
            exp_mem.push_back(m);
        end
        dc_addr = 32'h0000_4000; dc_we = 1'b0; dc_req = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (mem_req !== 1'b1 && w < 20);
        if (mem_req !== 1'b1) fail_now("mem_req_before_reset");
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_mem_req",  {31'b0, mem_req}, 32'd0);
        chk("rst2_mem_bus",  mem_addr | mem_wdata | {31'b0, mem_we}, 32'd0);
        chk("rst2_done_err", {28'b0, ic_done, ic_err, dc_done, dc_err}, 32'd0);
        chk("rst2_rdata",    ic_rdata | dc_rdata, 32'd0);
        chk("rst2_busy",     {31'b0, busy}, 32'd0);
        reset = 1'b0; dc_req = 1'b0;
        m_starve = 0; m_ic_rd = '0; m_dc_rd = '0;
        repeat (4) @(negedge clk);

        // Randomised episodes with random ack delays and stray acks.
        ack_delay = -1;
        spurious_en = 1'b1;
        for (int ep = 0; ep < 40; ep++) begin
            int ni = $urandom_range(0, 3);
            int nd = $urandom_range(0, 6);
            if (ni + nd == 0) ni = 1;
            clear_lists();
            for (int k = 0; k < ni; k++) i_addr.push_back($urandom & 32'hFFFF_FFFC);
            for (int k = 0; k < nd; k++) add_d($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom);
            run_episode(-1, 1'b0);
        end
        spurious_en = 1'b0;
        repeat (4) @(negedge clk);

        chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
        chk("mem_queue_empty", exp_mem.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive D-port grants while the I-port is pending.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 255: the maximum number of cycles to wait for mem_ack before aborting.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ic_req, input, 1 bit: instruction-cache read request, held until ic_done.
REQ-006 The block SHALL have port ic_addr, input, 32 bits: instruction read address, stable while ic_req is high.
REQ-007 The block SHALL have ports ic_done, ic_err, output, 1 bit each: completion pulse and timeout-error pulse for the I-port.
REQ-008 The block SHALL have port ic_rdata, output, 32 bits: I-port read data, valid in the ic_done cycle.
REQ-009 The block SHALL have ports dc_req and dc_we, input, 1 bit each: data-cache request and write enable (1 = write), held until dc_done.
REQ-010 The block SHALL have ports dc_addr and dc_wdata, input, 32 bits each: data address and write data, stable while dc_req is high.
REQ-011 The block SHALL have ports dc_done and dc_err, output, 1 bit each, and port dc_rdata, output, 32 bits: the D-port equivalents of the I-port outputs.
REQ-012 The block SHALL have ports mem_req and mem_we, output, 1 bit each, and ports mem_addr and mem_wdata, output, 32 bits each: the backing-memory request.
REQ-013 The block SHALL have port mem_ack, input, 1 bit, and port mem_rdata, input, 32 bits: memory accepts and completes the request in the mem_ack cycle.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, MEM_I, MEM_D and RESP; at most one memory transaction is outstanding at any time.
REQ-016 Arbitration SHALL occur only in IDLE:
- Only one of ic_req/dc_req high: that port wins.
- Both high: D wins, unless starve_cnt == STARVE_LIMIT, in which case I wins.
REQ-017 The starve_cnt counter SHALL update at each IDLE arbitration:
- Increment, saturating at STARVE_LIMIT, when D wins while ic_req is high.
- Clear when I wins, or when D wins with ic_req low.
REQ-018 On a grant in cycle N, the block SHALL register the winner's address, write enable (0 for I) and write data, enter MEM_I or MEM_D, and drive mem_req=1 from cycle N+1.
REQ-019 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered, and SHALL hold stable until the cycle after mem_ack or timeout.
REQ-020 In the mem_ack cycle M, the block SHALL capture mem_rdata into the granted port's rdata register and go to RESP; mem_req SHALL be 0 from M+1.
REQ-021 In RESP (cycle M+1), the block SHALL pulse the granted port's done signal for exactly one cycle, ignore all requests, and go to IDLE; new arbitration happens no earlier than M+2.
REQ-022 For D writes, dc_rdata SHALL be left unchanged; the non-granted port's rdata SHALL never change.
REQ-023 A wait counter SHALL clear on grant and increment every cycle in MEM_I/MEM_D without mem_ack.
REQ-024 If the wait counter reaches MEM_TIMEOUT with no ack, the block SHALL drop mem_req and go to RESP; done and err SHALL pulse together and rdata SHALL be unchanged.
REQ-025 If mem_ack arrives in the same cycle the counter reaches MEM_TIMEOUT, the ack SHALL win: normal completion, no err.
REQ-026 A mem_ack seen in IDLE or RESP SHALL be ignored.
REQ-027 A requester dropping req mid-transaction SHALL NOT abort the transaction; the done pulse still occurs.
REQ-028 Minimum latency from req sampled in IDLE to done SHALL be 3 cycles, with mem_ack on the first mem_req cycle.

Reset
REQ-029 While reset is high, the block SHALL force state IDLE and clear starve_cnt, the wait counter, mem_req, mem_we, mem_addr, mem_wdata, all done/err outputs, ic_rdata, dc_rdata and busy to 0.
REQ-030 Reset asserted mid-transaction SHALL give mem_req=0 in the cycle after the reset edge, with no done or err pulse; a pending mem_ack SHALL be discarded.

Verification
REQ-031 Single I read: ic_req, ic_addr=0x40, ack on the first mem_req cycle with mem_rdata=0x8C220004 -> ic_done with ic_rdata=0x8C220004, 3 cycles after the request is sampled.
REQ-032 D write: dc_we=1, dc_addr=0x100, dc_wdata=0xDEADBEEF, ack after 2 wait cycles -> mem_we=1 with that addr/data, dc_done pulse, dc_rdata unchanged.
REQ-033 Starvation: ic_req and dc_req both held high continuously, ack in 1 cycle -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-034 Timeout: MEM_TIMEOUT=255, mem_ack never asserted -> mem_req drops, and ic_done and ic_err pulse together 257 cycles after the request is sampled.
REQ-035 Reset asserted in MEM_D, with mem_ack in the same cycle -> no dc_done; all outputs 0 on the next cycle.
REQ-036 Back-to-back: dc_req held high through dc_done -> a second D grant, with mem_req rising 2 cycles after the first done cycle; no grant ever occurs in a RESP cycle.
